// File: rtl/axil_regfile.sv
// AXI4-lite register file with byte-strobed writable registers and read-only
// registers that reflect hardware status. Write address and write data are
// accepted independently into one-entry holding buffers; reads are served
// from a single outstanding-read slot with a registered result.
module axil_regfile #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic                           wavalid,
  output logic                           waready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam int         ADDR_LSB    = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int         IDX_W       = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  aw_held;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  commit;
  logic [NUM_REGS-1:0]   wr_hit;
  logic [IDX_W-1:0]      ar_idx;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_addr_bits;

  // Sub-word address bits carry no meaning for word-sized registers.
  assign unused_addr_bits = ^{waddr[ADDR_LSB-1:0], raddr[ADDR_LSB-1:0]};

  assign waready = !aw_held;
  assign wready  = !w_held;
  assign arready = !rvalid;
  assign commit  = aw_held & w_held & !bvalid;
  assign ar_idx  = raddr[ADDR_WIDTH-1:ADDR_LSB];

  // Write-address holding buffer: capture on handshake, release on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      aw_idx  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
    end else if (wavalid && !aw_held) begin
      aw_held <= 1'b1;
      aw_idx  <= waddr[ADDR_WIDTH-1:ADDR_LSB];
    end
  end

  // Write-data holding buffer: capture on handshake, release on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_held <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (commit) begin
      w_held <= 1'b0;
    end else if (wvalid && !w_held) begin
      w_held <= 1'b1;
      w_data <= wdata;
      w_strb <= wstrb;
    end
  end

  // One storage slice per register; read-only slots hold no state and
  // can never be hit by a write, which turns such writes into SLVERR.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (RO_MASK[gi]) begin : g_ro
        assign wr_hit[gi]                          = 1'b0;
        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] value;
        assign wr_hit[gi] = commit && (aw_idx == IDX_W'(gi));

        // Byte-lane update on a commit addressed to this register.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            value <= '0;
          end else if (wr_hit[gi]) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (w_strb[b]) value[b*8 +: 8] <= w_data[b*8 +: 8];
            end
          end
        end

        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = value;
      end
    end
  endgenerate

  // Write response and strobe: wr_pulse lands in the same cycle the new
  // register value becomes visible; bresp is held until bready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= wr_hit;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
        bresp  <= RESP_OKAY;
      end
    end
  end

  // Read selection: stored value or live hardware status; zero when out of range.
  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_hit = 1'b1;
        rd_val = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH]
                            : reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Single outstanding read: result registered at the AR handshake, which
  // naturally returns the pre-write value on a same-edge commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (arvalid && !rvalid) begin
      rvalid <= 1'b1;
      rdata  <= rd_val;
      rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Self-checking bench for axil_regfile: directed corner sequences, a vector
// table of writes with readback, and randomized traffic against a model.
module tb_axil_regfile;

  localparam int              DW     = 32;
  localparam int              ADDR_W = 8;
  localparam int              NR     = 16;
  localparam logic [NR-1:0]   RO     = 16'h8010;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] waddr = '0;
  logic              wavalid = 1'b0;
  logic              waready;
  logic [DW-1:0]     wdata = '0;
  logic [DW/8-1:0]   wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [ADDR_W-1:0] raddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [NR*DW-1:0]  hw_status = '0;
  logic [NR*DW-1:0]  reg_q;
  logic [NR-1:0]     wr_pulse;

  always #5 clk = ~clk;

  axil_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(ADDR_W), .NUM_REGS(NR), .RO_MASK(RO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .waddr(waddr), .wavalid(wavalid), .waready(waready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .raddr(raddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .hw_status(hw_status), .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array of register contents.
  logic [DW-1:0] mdl [NR];

  task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model_write(input int idx, input logic [DW-1:0] d, input logic [3:0] s);
    if (idx >= NR) return 2'b10;
    if (RO[idx]) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
    return 2'b00;
  endfunction

  function automatic void model_read(input int idx, output logic [DW-1:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b10;
    if (idx < NR) begin
      r = 2'b00;
      if (RO[idx]) d = hw_status[idx*DW +: DW];
      else         d = mdl[idx];
    end
  endfunction

  function automatic logic [NR*DW-1:0] model_regq();
    logic [NR*DW-1:0] p;
    p = '0;
    for (int i = 0; i < NR; i++) if (!RO[i]) p[i*DW +: DW] = mdl[i];
    return p;
  endfunction

  // Write with AW and W presented together; checks response, strobe, contents.
  task automatic do_write(input int idx, input logic [DW-1:0] d, input logic [3:0] s, output logic [1:0] resp);
    logic [1:0]    exp;
    logic [NR-1:0] exp_pulse;
    bit            aw_hs, w_hs;
    int            cyc;
    exp       = model_write(idx, d, s);
    exp_pulse = (exp == 2'b00) ? (NR'(1) << idx) : '0;
    waddr   = ADDR_W'(idx * 4 + int'($urandom_range(0, 3)));
    wdata   = d;
    wstrb   = s;
    wavalid = 1'b1;
    wvalid  = 1'b1;
    cyc = 0;
    while ((wavalid || wvalid) && cyc < 20) begin
      aw_hs = wavalid && waready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) wavalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      cyc++;
    end
    wavalid = 1'b0;
    wvalid  = 1'b0;
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("wr_bvalid_seen", bvalid, 1'b1);
    resp = bresp;
    check("wr_bresp", bresp, exp);
    check("wr_pulse", wr_pulse, exp_pulse);
    check("wr_reg_q", reg_q, model_regq());
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("wr_bvalid_clear", bvalid, 1'b0);
    check("wr_pulse_clear", wr_pulse, '0);
  endtask

  task automatic do_read(input int idx, output logic [DW-1:0] d, output logic [1:0] r);
    bit hs;
    int cyc;
    raddr   = ADDR_W'(idx * 4 + int'($urandom_range(0, 3)));
    arvalid = 1'b1;
    cyc = 0;
    while (arvalid && cyc < 20) begin
      hs = arready;
      @(posedge clk); #1;
      if (hs) arvalid = 1'b0;
      cyc++;
    end
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rd_rvalid_seen", rvalid, 1'b1);
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp, rr, er;
    logic [31:0] rd, ed;
    int          idx;

    for (int i = 0; i < NR; i++) begin
      mdl[i] = '0;
      hw_status[i*DW +: DW] = $urandom;
    end
    hw_status[4*DW +: DW]  = 32'hC0DE0004;
    hw_status[15*DW +: DW] = 32'hC0DE000F;

    vecs[0] = '{3,  32'hFFFFFFFF, 4'hF, 2'b00, 32'hFFFFFFFF, 2'b00};
    vecs[1] = '{3,  32'h00000000, 4'h5, 2'b00, 32'hFF00FF00, 2'b00};
    vecs[2] = '{3,  32'h12345678, 4'h0, 2'b00, 32'hFF00FF00, 2'b00};
    vecs[3] = '{7,  32'hA5A5A5A5, 4'hF, 2'b00, 32'hA5A5A5A5, 2'b00};
    vecs[4] = '{7,  32'h00005A00, 4'h2, 2'b00, 32'hA5A55AA5, 2'b00};
    vecs[5] = '{16, 32'h11111111, 4'hF, 2'b10, 32'h00000000, 2'b10};
    vecs[6] = '{4,  32'h22222222, 4'hF, 2'b10, 32'hC0DE0004, 2'b00};
    vecs[7] = '{15, 32'h33333333, 4'hF, 2'b10, 32'hC0DE000F, 2'b00};
    vecs[8] = '{17, 32'h44444444, 4'hF, 2'b10, 32'h00000000, 2'b10};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_waready", waready, 1'b1);
    check("rst_wready", wready, 1'b1);
    check("rst_arready", arready, 1'b1);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, '0);
    check("rst_bresp", bresp, '0);
    check("rst_rresp", rresp, '0);
    check("rst_reg_q", reg_q, '0);
    check("rst_wr_pulse", wr_pulse, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_bvalid", bvalid, 1'b0);

    // AW and W together: response two edges after presentation
    waddr = 8'd8; wdata = 32'hDEADBEEF; wstrb = 4'hF; wavalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    wavalid = 1'b0; wvalid = 1'b0;
    check("same_bvalid_e0", bvalid, 1'b0);
    check("same_waready_e0", waready, 1'b0);
    check("same_wready_e0", wready, 1'b0);
    @(posedge clk); #1;
    void'(model_write(2, 32'hDEADBEEF, 4'hF));
    check("same_bvalid_e1", bvalid, 1'b1);
    check("same_bresp_e1", bresp, 2'b00);
    check("same_wr_pulse_e1", wr_pulse, 16'h0004);
    check("same_reg2", reg_q[2*DW +: DW], 32'hDEADBEEF);
    @(posedge clk); #1;
    check("same_wr_pulse_e2", wr_pulse, '0);
    check("same_bvalid_hold", bvalid, 1'b1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("same_bvalid_clear", bvalid, 1'b0);

    // W three cycles ahead of AW
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("wfirst_wready_low", wready, 1'b0);
      check("wfirst_no_bvalid", bvalid, 1'b0);
      if (c < 2) begin @(posedge clk); #1; end
    end
    waddr = 8'd4; wavalid = 1'b1;
    @(posedge clk); #1;
    wavalid = 1'b0;
    check("wfirst_bvalid_early", bvalid, 1'b0);
    @(posedge clk); #1;
    void'(model_write(1, 32'h11223344, 4'hF));
    check("wfirst_bvalid", bvalid, 1'b1);
    check("wfirst_pulse", wr_pulse, 16'h0002);
    check("wfirst_reg1", reg_q[1*DW +: DW], 32'h11223344);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;

    // Vector table: write then read back
    foreach (vecs[k]) begin
      do_write(vecs[k].idx, vecs[k].data, vecs[k].strb, resp);
      check($sformatf("vec%0d_bresp", k), resp, vecs[k].exp_bresp);
      do_read(vecs[k].idx, rd, rr);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
      check($sformatf("vec%0d_rresp", k), rr, vecs[k].exp_rresp);
    end

    // Read held by rready low for 5 cycles
    raddr = 8'd28; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("stall_rvalid", rvalid, 1'b1);
      check("stall_rdata", rdata, 32'hA5A55AA5);
      check("stall_arready", arready, 1'b0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("stall_rvalid_clear", rvalid, 1'b0);

    // Same-edge read and write commit on reg0
    do_write(0, 32'd5, 4'hF, resp);
    waddr = 8'd0; wdata = 32'd9; wstrb = 4'hF; wavalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    wavalid = 1'b0; wvalid = 1'b0;
    raddr = 8'd0; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    void'(model_write(0, 32'd9, 4'hF));
    check("collide_rvalid", rvalid, 1'b1);
    check("collide_rdata_old", rdata, 32'd5);
    check("collide_bvalid", bvalid, 1'b1);
    check("collide_reg0_new", reg_q[0 +: DW], 32'd9);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      hw_status[4*DW +: DW]  = $urandom;
      hw_status[15*DW +: DW] = $urandom;
      idx = int'($urandom_range(0, 17));
      if ($urandom_range(0, 1) == 1) begin
        do_write(idx, $urandom, 4'($urandom_range(0, 15)), resp);
      end else begin
        model_read(idx, ed, er);
        do_read(idx, rd, rr);
        check($sformatf("rand%0d_rdata_idx%0d", n, idx), rd, ed);
        check($sformatf("rand%0d_rresp_idx%0d", n, idx), rr, er);
      end
    end
    check("rand_final_reg_q", reg_q, model_regq());

    // Reset asserted while a write response is pending
    waddr = 8'd20; wdata = 32'hCAFEF00D; wstrb = 4'hF; wavalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    wavalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_pre_bvalid", bvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", bvalid, 1'b0);
    check("mid_rst_reg_q", reg_q, '0);
    check("mid_rst_wr_pulse", wr_pulse, '0);
    check("mid_rst_waready", waready, 1'b1);
    check("mid_rst_wready", wready, 1'b1);
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale_b", bvalid, 1'b0);
    end
    do_read(5, rd, rr);
    check("post_rst_reg5", rd, 32'd0);
    check("post_rst_reg5_resp", rr, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
AXIL_REGFILE -- requirements
Module: axil_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the AXI-lite data bus and of each register; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: width of the byte address.
REQ-003 SHALL have parameter NUM_REGS, default 16: number of registers, 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 SHALL have parameter RO_MASK, default 0: NUM_REGS-bit mask; bit i=1 makes register i read-only and driven by hardware.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have ports waddr (input, ADDR_WIDTH), wavalid (input, 1) and waready (output, 1): write address channel.
REQ-008 SHALL have ports wdata (input, DATA_WIDTH), wstrb (input, DATA_WIDTH/8), wvalid (input, 1) and wready (output, 1): write data channel.
REQ-009 SHALL have ports bresp (output, 2), bvalid (output, 1) and bready (input, 1): write response channel.
REQ-010 SHALL have ports raddr (input, ADDR_WIDTH), arvalid (input, 1) and arready (output, 1): read address channel.
REQ-011 SHALL have ports rdata (output, DATA_WIDTH), rresp (output, 2), rvalid (output, 1) and rready (input, 1): read data channel.
REQ-012 SHALL have port hw_status, input, NUM_REGS*DATA_WIDTH: hardware values for read-only registers; register i occupies slice i.
REQ-013 SHALL have port reg_q, output, NUM_REGS*DATA_WIDTH: current contents of the writable registers, packed the same way.
REQ-014 SHALL have port wr_pulse, output, NUM_REGS: one-hot, one-cycle strobe for each successful write.

Function
REQ-015 SHALL form the register index as addr >> log2(DATA_WIDTH/8) and ignore the low address bits.
REQ-016 SHALL accept AW and W independently, each into its own one-entry holding buffer; waready = !aw_held and wready = !w_held.
REQ-017 SHALL commit a write on the edge where aw_held & w_held & !bvalid, then clear both buffers and set bvalid on the next cycle.
REQ-018 SHALL update only the byte lanes whose wstrb bit is 1 on a commit; wstrb=0 commits with no data change and still returns OKAY.
REQ-019 SHALL return bresp=OKAY (00) and pulse wr_pulse[i] for one cycle, coincident with the register update, when index < NUM_REGS and RO_MASK[i]=0.
REQ-020 SHALL return bresp=SLVERR (10), change no register and assert no wr_pulse when index >= NUM_REGS or RO_MASK[i]=1.
REQ-021 SHALL hold bvalid and bresp stable until bready; they clear on the bvalid&bready edge, and a new commit may occur on the cycle after that.
REQ-022 SHALL support one outstanding read, with arready = !rvalid.
REQ-023 SHALL register the read result on the arvalid&arready edge and assert rvalid on the next cycle.
REQ-024 SHALL hold rdata, rresp and rvalid stable until rready.
REQ-025 SHALL return for reads: writable register -> stored value, OKAY; read-only register -> hw_status slice sampled at the AR handshake, OKAY; index >= NUM_REGS -> 0, SLVERR.
REQ-026 SHALL return the pre-write value when a read handshake and a write commit target the same register on the same edge.
REQ-027 SHALL keep the read and write paths fully independent; neither channel stalls the other.
REQ-028 SHALL hold reg_q at 0 for read-only register slices.

Reset
REQ-029 SHALL drive, while rst_n=0, all registers, both holding buffers, bvalid, rvalid, rdata, bresp, rresp and wr_pulse to 0, and waready, wready and arready to 1 after reset.
REQ-030 SHALL discard any in-flight transaction when reset asserts mid-operation and produce no response for it after release.
REQ-031 SHALL ignore handshakes during the cycle rst_n deasserts only if they violate setup; otherwise the first rising edge after deassertion is a normal cycle.

Verification
REQ-032 SHALL verify: AW idx 2 + W 0xDEADBEEF, wstrb=F, same cycle -> bvalid 2 cycles later, bresp=00, wr_pulse[2] one cycle, reg_q slice 2 = 0xDEADBEEF.
REQ-033 SHALL verify: W 0x11223344 three cycles before AW idx 1 -> wready=0 while W is held, commit follows AW, reg1=0x11223344.
REQ-034 SHALL verify: reg3=0xFFFFFFFF, write 0x00000000 with wstrb=0101 -> reg3=0xFF00FF00.
REQ-035 SHALL verify: write to idx NUM_REGS and to an RO_MASK register -> bresp=10, no register change, no wr_pulse; read of idx NUM_REGS -> rdata=0, rresp=10.
REQ-036 SHALL verify: rready held 0 for 5 cycles -> rvalid, rdata stable and arready=0 throughout; same-edge read and write of reg0 (old 5, new 9) -> rdata=5.
REQ-037 SHALL verify: rst_n pulsed low while B is pending -> bvalid=0, all registers 0, no stale response after release.
